// File: rtl/sa_result_drain_pkg.sv
// Shared types and helpers for the systolic-array result drain controller.
// Holds the FSM state type, the default word width and the compute-pass length.
package sa_result_drain_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    // Cycles needed to fill the skew, stream K beats and empty the skew again.
    function automatic int run_len(input int k, input int n);
        return k + 2 * n - 1;
    endfunction

endpackage

// File: rtl/sa_result_drain_if.sv
// Control and result-stream signals between the drain controller and its environment.
// slave is the controller's view, master is the view of whoever drives it.
interface sa_result_drain_if #(
    parameter int DW = 8,
    parameter int N  = 2
);
    localparam int IDXW = (N * N > 1) ? $clog2(N * N) : 1;

    logic              start;
    logic [N*N*DW-1:0] s_in;
    logic              out_ready;
    logic              acc_clr;
    logic              feed_en;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IDXW-1:0]   out_idx;
    logic              out_last;
    logic              busy;
    logic              done;

    modport slave (
        input  start, s_in, out_ready,
        output acc_clr, feed_en, out_valid, out_data, out_idx, out_last, busy, done
    );

    modport master (
        output start, s_in, out_ready,
        input  acc_clr, feed_en, out_valid, out_data, out_idx, out_last, busy, done
    );
endinterface

// File: rtl/sa_result_drain.sv
// Sequences one compute pass of an N x N systolic array (clear, feed, capture)
// and then streams the captured results out in row-major order.
module sa_result_drain
    import sa_result_drain_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int N  = 2,
    parameter int K  = 4
) (
    input  logic            clk,
    input  logic            rst,
    sa_result_drain_if.slave bus,
    output state_t          dbg_state
);

    localparam int NW      = N * N;
    localparam int IDXW    = (NW > 1) ? $clog2(NW) : 1;
    localparam int RUN_LEN = run_len(K, N);
    localparam int CW      = $clog2(RUN_LEN + 1);

    localparam logic [CW-1:0]   LAST_RUN = CW'(RUN_LEN - 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NW - 1);

    state_t          state;
    logic [CW-1:0]   run_cnt;
    logic [DW-1:0]   shadow [NW];
    logic            acc_clr_q;
    logic            feed_en_q;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic [IDXW-1:0] out_idx_q;
    logic            out_last_q;
    logic            done_q;
    logic [IDXW-1:0] nxt_idx;

    assign nxt_idx = out_idx_q + 1'b1;

    // Output stream: a word moves when out_valid and out_ready are both high on a
    // rising edge; out_valid never looks at out_ready, and while the sink stalls
    // out_data, out_idx and out_last stay frozen until that transfer happens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            run_cnt     <= '0;
            acc_clr_q   <= 1'b0;
            feed_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= CLEAR;
                        acc_clr_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    state     <= RUN;
                    feed_en_q <= 1'b1;
                    run_cnt   <= '0;
                end
                RUN: begin
                    if (run_cnt == LAST_RUN) begin
                        state     <= CAPTURE;
                        feed_en_q <= 1'b0;
                        run_cnt   <= '0;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    // Word 0 is taken straight from s_in since the shadow loads on this same edge.
                    for (int i = 0; i < NW; i++) begin
                        shadow[i] <= bus.s_in[i*DW +: DW];
                    end
                    out_data_q  <= bus.s_in[0 +: DW];
                    out_idx_q   <= '0;
                    out_last_q  <= (NW == 1);
                    out_valid_q <= 1'b1;
                    state       <= DRAIN;
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (out_idx_q == LAST_IDX) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_idx_q   <= '0;
                            done_q      <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            out_idx_q  <= nxt_idx;
                            out_data_q <= shadow[nxt_idx];
                            out_last_q <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.acc_clr   = acc_clr_q;
    assign bus.feed_en   = feed_en_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state != IDLE);
    assign dbg_state     = state;

endmodule

// File: doc/sa_result_drain.md
SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

Interface
REQ-001 Parameter DW, default 8, width of one result word.
REQ-002 Parameter N, default 2, array dimension; the array holds N x N results.
REQ-003 Parameter K, default 4, number of activation/weight beats per compute pass.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low; 0 forces reset state immediately.
REQ-006 start  input  1  request one compute pass plus drain; sampled only in IDLE.
REQ-007 s_in  input  N*N*DW  array results, flattened; element [i][j] at bits (i*N+j)*DW +: DW.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 acc_clr  output  1  one-cycle clear to the array accumulators.
REQ-010 feed_en  output  1  high while the feeder must stream w/a beats into the array.
REQ-011 out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-012 out_data  output  DW  one result word.
REQ-013 out_idx  output  clog2(N*N)  row-major index i*N+j of out_data.
REQ-014 out_last  output  1  high with the final word (index N*N-1).
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, RUN, CAPTURE, DRAIN.
REQ-018 IDLE -> CLEAR when start=1; start in any other state SHALL be ignored (no queuing).
REQ-019 CLEAR SHALL last exactly 1 cycle with acc_clr=1, then go to RUN.
REQ-020 RUN SHALL last exactly K+2N-1 cycles (skew fill + K beats + drain of skew), feed_en=1 throughout, then go to CAPTURE.
REQ-021 RUN cycle counter SHALL be wide enough for K+2N-1 and reset to 0 on entry to RUN.
REQ-022 CAPTURE SHALL last 1 cycle and latch all N*N words of s_in into a shadow buffer; later s_in changes SHALL not affect drained data.
REQ-023 DRAIN SHALL present shadow words in row-major order, index 0 first, out_valid=1.
REQ-024 Handshake: a word transfers when out_valid=1 and out_ready=1; index advances only on transfer.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_idx, out_last SHALL hold stable.
REQ-026 out_valid SHALL not depend combinationally on out_ready.
REQ-027 out_last=1 exactly when out_valid=1 and out_idx=N*N-1.
REQ-028 Transfer of the last word SHALL move DRAIN -> IDLE and assert done the next cycle for 1 cycle.
REQ-029 start asserted in the same cycle as done SHALL be accepted (FSM is IDLE), entering CLEAR next cycle.
REQ-030 Back-to-back readiness SHALL drain N*N words in N*N consecutive cycles.
REQ-031 out_data, acc_clr, feed_en, out_valid SHALL be register outputs (no combinational path from inputs).

Reset
REQ-032 rst=0 SHALL force state IDLE, counters 0, shadow buffer 0, all outputs 0, asynchronously.
REQ-033 Reset asserted mid-RUN or mid-DRAIN SHALL abort the pass; no done, no further words after release.
REQ-034 After rst release the block SHALL accept start on the first clock edge.

Structure
REQ-035 Shared package SHALL hold the state enum type, DW default, and the RUN-length function K+2N-1.
REQ-036 Word counter and shadow buffer SHALL be local; no sub-module needed beyond the block itself; optional sub-module sa_shadow_buf for the N*N capture register.

Verification
REQ-037 Reset then start pulse, N=2, K=4 -> acc_clr high 1 cycle at cycle 1, feed_en high cycles 2..8 (7 cycles), capture at cycle 9.
REQ-038 s_in = {8'h04,8'h03,8'h02,8'h01} at capture, out_ready=1 -> words 01,02,03,04 with idx 0..3 on 4 consecutive cycles, out_last on 04, done next cycle.
REQ-039 out_ready toggled 1,0,0,1,1,0,1 during DRAIN -> exactly 4 transfers, held data stable on stalled cycles, order unchanged.
REQ-040 s_in changed to 8'hFF everywhere right after CAPTURE -> drained words still 01..04.
REQ-041 start asserted during RUN and DRAIN -> ignored; start in done cycle -> new acc_clr next cycle.
REQ-042 rst=0 asserted in DRAIN after word 1 -> out_valid, busy drop immediately, no done; following start runs a clean pass.
